// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared control codes, FSM state type and defaults for the SD-card SPI master.
package sd_spi_pkg;

  // Control codes written alongside the command strobe
  localparam logic [1:0] SPI_PUT  = 2'd0;
  localparam logic [1:0] SPI_INIT = 2'd1;
  localparam logic [1:0] SPI_CE0  = 2'd2;
  localparam logic [1:0] SPI_CE1  = 2'd3;

  // Default number of SCLK pulses in the card wake-up sequence
  localparam int INIT_CLOCKS_DEF = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    INIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sd_spi_tick.sv
// sd_spi_tick: half-period divider. Emits a one-cycle tick every DIV cycles while
// clr is low; clr holds the count at zero so the first tick after release lands
// exactly DIV cycles later.
module sd_spi_tick #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = !clr && (cnt_q == DIV_M1);

  // Next count: hold at zero while cleared, wrap on tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi.sv
// sd_spi: mode-0 SPI master for the SD card slot. Byte transfers (PUT), the
// card wake-up clock burst (INIT) and chip-select control (CE0/CE1).
// Optional feature macro: SD_SPI_DONE_EN adds a one-cycle `done` pulse when a
// PUT or INIT finishes.
module sd_spi
  import sd_spi_pkg::*;
#(
  parameter int DIV         = 1,
  parameter int INIT_CLOCKS = INIT_CLOCKS_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd,
  input  logic [1:0] ctl,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
`ifdef SD_SPI_DONE_EN
  output logic       done,
`endif
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int PW = (INIT_CLOCKS > 1) ? $clog2(INIT_CLOCKS) : 1;
  localparam logic [PW-1:0] LAST_PULSE = PW'(INIT_CLOCKS - 1);

  state_e        state_q, state_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic          tick;

  // The divider sits at zero whenever idle, so it is freshly cleared on every
  // entry into SHIFT or INIT.
  sd_spi_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state_q == IDLE),
    .tick    (tick)
  );

  assign busy     = (state_q != IDLE);
  assign dout     = dout_q;
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

  // Next-state and datapath: commands are only decoded in IDLE, so strobes
  // arriving mid-transfer are dropped without side effects.
  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;
    dout_d      = dout_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd) begin
          case (ctl)
            SPI_PUT: begin
              shift_d   = din;
              mosi_d    = din[7];
              bit_cnt_d = 3'd0;
              state_d   = SHIFT;
            end
            SPI_INIT: begin
              cs_d        = 1'b1;
              mosi_d      = 1'b1;
              pulse_cnt_d = '0;
              state_d     = INIT;
            end
            SPI_CE0: cs_d = 1'b0;
            SPI_CE1: cs_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising edge: sample MISO into the LSB
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], spi_miso};
          end else begin
            // Falling edge: next MSB out, or finish after the eighth bit
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              dout_d  = shift_q;
              mosi_d  = 1'b1;
              state_d = IDLE;
            end else begin
              mosi_d    = shift_q[7];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
      end
      INIT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (sclk_q) begin
            if (pulse_cnt_q == LAST_PULSE) begin
              state_d = IDLE;
            end else begin
              pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      cs_q        <= 1'b1;
      dout_q      <= 8'hFF;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      dout_q      <= dout_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

`ifdef SD_SPI_DONE_EN
  logic done_q;
  logic done_d;

  assign done   = done_q;
  assign done_d = (state_q != IDLE) && (state_d == IDLE);

  // Completion pulse, coincident with busy falling
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

endmodule
